// File: rtl/rv4028_bus_pkg.sv
// Shared types and constants for the RV4028 external bus interface unit.
package rv4028_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    T1,
    T2,
    T3
  } state_t;

  localparam logic [31:0] IO_MASK_DEF  = 32'hF000_0000;
  localparam logic [31:0] IO_MATCH_DEF = 32'hF000_0000;

  function automatic int unsigned beat_count(input int unsigned bus_w);
    return 32 / bus_w;
  endfunction

  // Instantiating modules use this in a generate-time check.
  function automatic bit bus_w_legal(input int unsigned bus_w);
    return (bus_w == 8) || (bus_w == 16);
  endfunction

endpackage

// File: rtl/rv4028_wait_ctr.sv
// T2 cycle counter: loaded to 1 on entry to T2, saturates at its maximum.
module rv4028_wait_ctr #(
  parameter int unsigned MIN_WAIT     = 1,
  parameter int unsigned WAIT_TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic min_done,
  output logic timed_out
);

  localparam int unsigned MAXV = (MIN_WAIT > WAIT_TIMEOUT) ? MIN_WAIT : WAIT_TIMEOUT;
  localparam int unsigned CW   = $clog2(MAXV + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CW'(1);
    end else if (cnt != CW'(MAXV)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign min_done  = (cnt >= CW'(MIN_WAIT));
  assign timed_out = (WAIT_TIMEOUT != 0) && (cnt >= CW'(WAIT_TIMEOUT));

endmodule

// File: rtl/rv4028_bus_if.sv
// Core word port to RV4028 external bus: splits words into beats, T1/T2/T3 timing,
// wait-state insertion, optional wait timeout and memory/I-O decode.
module rv4028_bus_if
  import rv4028_bus_pkg::*;
#(
  parameter int unsigned BUS_W        = 16,
  parameter int unsigned MIN_WAIT     = 1,
  parameter int unsigned WAIT_TIMEOUT = 0,
  parameter logic [31:0] IO_MASK      = IO_MASK_DEF,
  parameter logic [31:0] IO_MATCH     = IO_MATCH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_addr,
  input  logic [3:0]         req_wmask,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  output logic               rsp_err,
  output logic [31:0]        rsp_rdata,
  output logic [31:0]        addr,
  output logic [BUS_W-1:0]   data_out,
  output logic               data_oe,
  input  logic [BUS_W-1:0]   data_in,
  output logic               rd_n,
  output logic               wr_n,
  output logic [BUS_W/8-1:0] wrm_n,
  output logic               mreq_n,
  output logic               iorq_n,
  input  logic               wait_n
);

  localparam int unsigned NB    = beat_count(BUS_W);
  localparam int unsigned BL    = BUS_W / 8;
  localparam logic [31:0] LMASK = 32'((64'd1 << BUS_W) - 64'd1);

  if (!bus_w_legal(BUS_W)) begin : g_bus_w_check
    $error("rv4028_bus_if: BUS_W must be 8 or 16");
  end

  state_t      state;
  logic [1:0]  beat;
  logic [29:0] base;
  logic [3:0]  wmask_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_acc;
  logic        io_q, wr_q, err_q;
  logic        min_done, timed_out;
  logic [2:0]  nb_first, nb_next;
  logic [31:0] lane_off;
  logic        req_io;

  // First beat at or after 'from' that must be issued; NB when none remain.
  function automatic logic [2:0] next_beat(input logic [3:0] m, input logic wr,
                                           input logic [2:0] from);
    logic [2:0] nb;
    logic [3:0] sl;
    nb = 3'(NB);
    for (int unsigned k = NB; k > 0; k--) begin
      sl = m >> ((k - 1) * BL);
      if ((3'(k - 1) >= from) && (!wr || (sl[BL-1:0] != '0))) nb = 3'(k - 1);
    end
    return nb;
  endfunction

  function automatic logic [31:0] beat_addr(input logic [29:0] b, input logic [1:0] k);
    return {b, 2'b00} + 32'(k) * BL;
  endfunction

  function automatic logic [BUS_W-1:0] lane(input logic [31:0] w, input logic [1:0] k);
    return BUS_W'(w >> (32'(k) * BUS_W));
  endfunction

  always_comb begin
    nb_first = next_beat(req_wmask, |req_wmask, 3'd0);
    nb_next  = next_beat(wmask_q, wr_q, {1'b0, beat} + 3'd1);
    lane_off = 32'(beat) * BUS_W;
    req_io   = ((req_addr & IO_MASK & ~32'h3) == (IO_MATCH & ~32'h3));
  end

  assign req_ready = (state == IDLE);

  rv4028_wait_ctr #(
    .MIN_WAIT    (MIN_WAIT),
    .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) u_wait_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (state == T1),
    .min_done (min_done),
    .timed_out(timed_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat      <= '0;
      base      <= '0;
      wmask_q   <= '0;
      wdata_q   <= '0;
      rdata_acc <= '0;
      io_q      <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      addr      <= '0;
      data_out  <= '0;
      data_oe   <= 1'b0;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      wrm_n     <= '1;
      mreq_n    <= 1'b1;
      iorq_n    <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            base    <= req_addr[31:2];
            wmask_q <= req_wmask;
            wdata_q <= req_wdata;
            wr_q    <= |req_wmask;
            io_q    <= req_io;
            err_q   <= 1'b0;
            beat    <= nb_first[1:0];
            addr    <= beat_addr(req_addr[31:2], nb_first[1:0]);
            data_oe <= |req_wmask;
            if (|req_wmask) data_out <= lane(req_wdata, nb_first[1:0]);
            state   <= T1;
          end
        end
        T1: begin
          mreq_n <= io_q;
          iorq_n <= ~io_q;
          rd_n   <= wr_q;
          wr_n   <= ~wr_q;
          wrm_n  <= wr_q ? ~BL'(wmask_q >> (32'(beat) * BL)) : '1;
          state  <= T2;
        end
        T2: begin
          if (min_done && wait_n) begin
            if (!wr_q) begin
              rdata_acc <= (rdata_acc & ~(LMASK << lane_off)) | (32'(data_in) << lane_off);
            end
            {mreq_n, iorq_n, rd_n, wr_n} <= '1;
            wrm_n <= '1;
            state <= T3;
          end else if (timed_out) begin
            {mreq_n, iorq_n, rd_n, wr_n} <= '1;
            wrm_n <= '1;
            err_q <= 1'b1;
            state <= T3;
          end
        end
        T3: begin
          // A timeout abandons any remaining beats of the word.
          if (!err_q && (nb_next < 3'(NB))) begin
            beat    <= nb_next[1:0];
            addr    <= beat_addr(base, nb_next[1:0]);
            data_oe <= wr_q;
            if (wr_q) data_out <= lane(wdata_q, nb_next[1:0]);
            state   <= T1;
          end else begin
            data_oe   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= err_q;
            if (!wr_q && !err_q) rsp_rdata <= rdata_acc;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv4028_bus_if.sv
// Scoreboard bench for rv4028_bus_if: three configurations, directed vectors,
// expected beats and responses queued by stimulus and checked by a bus monitor.
module tb_rv4028_bus_if;

  typedef struct {
    int          inst;
    logic [31:0] addr;
    logic [5:0]  ctl;   // {wr, oe, ~mreq_n, ~iorq_n, wrm_n[1:0]}
    logic [15:0] data;
    int          t2;
  } beat_t;

  typedef struct {
    int          inst;
    logic        err;
    logic        chk_rd;
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid [3];
  logic        req_ready [3];
  logic [31:0] req_addr  [3];
  logic [3:0]  req_wmask [3];
  logic [31:0] req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_err   [3];
  logic [31:0] rsp_rdata [3];
  logic [31:0] addr      [3];
  logic        data_oe   [3];
  logic        rd_n      [3];
  logic        wr_n      [3];
  logic        mreq_n    [3];
  logic        iorq_n    [3];
  logic        wait_n    [3];
  logic [31:0] rdw       [3];

  logic [15:0] dout0, dout1, din0, din1;
  logic [7:0]  dout2, din2;
  logic [1:0]  wrm0, wrm1;
  logic [0:0]  wrm2;
  logic [15:0] dout_v [3];
  logic [1:0]  wrm_v  [3];

  assign din0 = addr[0][1] ? rdw[0][31:16] : rdw[0][15:0];
  assign din1 = addr[1][1] ? rdw[1][31:16] : rdw[1][15:0];
  assign din2 = 8'h5A;
  assign dout_v[0] = dout0;
  assign dout_v[1] = dout1;
  assign dout_v[2] = {8'h00, dout2};
  assign wrm_v[0]  = wrm0;
  assign wrm_v[1]  = wrm1;
  assign wrm_v[2]  = {1'b1, wrm2};

  rv4028_bus_if #(.BUS_W(16), .MIN_WAIT(1), .WAIT_TIMEOUT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_wmask(req_wmask[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_err(rsp_err[0]), .rsp_rdata(rsp_rdata[0]),
    .addr(addr[0]), .data_out(dout0), .data_oe(data_oe[0]), .data_in(din0),
    .rd_n(rd_n[0]), .wr_n(wr_n[0]), .wrm_n(wrm0), .mreq_n(mreq_n[0]),
    .iorq_n(iorq_n[0]), .wait_n(wait_n[0]));

  rv4028_bus_if #(.BUS_W(16), .MIN_WAIT(3), .WAIT_TIMEOUT(4)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_wmask(req_wmask[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_err(rsp_err[1]), .rsp_rdata(rsp_rdata[1]),
    .addr(addr[1]), .data_out(dout1), .data_oe(data_oe[1]), .data_in(din1),
    .rd_n(rd_n[1]), .wr_n(wr_n[1]), .wrm_n(wrm1), .mreq_n(mreq_n[1]),
    .iorq_n(iorq_n[1]), .wait_n(wait_n[1]));

  rv4028_bus_if #(.BUS_W(8), .MIN_WAIT(1), .WAIT_TIMEOUT(0)) u2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_addr(req_addr[2]), .req_wmask(req_wmask[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_err(rsp_err[2]), .rsp_rdata(rsp_rdata[2]),
    .addr(addr[2]), .data_out(dout2), .data_oe(data_oe[2]), .data_in(din2),
    .rd_n(rd_n[2]), .wr_n(wr_n[2]), .wrm_n(wrm2), .mreq_n(mreq_n[2]),
    .iorq_n(iorq_n[2]), .wait_n(wait_n[2]));

  int    cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t beat_q[$];
  rsp_t  rsp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    stim_tmo = 0;
  int    tmo_seen = 0;
  int    idle_req = 0;
  int    idle_seen = 0;
  bit    done_req = 0;
  bit    fin = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: reconstructs each external beat from the strobes and checks responses.
  beat_t cur [3];
  bit    act [3];
  always @(negedge clk) begin
    beat_t eb;
    rsp_t  er;
    for (int g = 0; g < 3; g++) begin
      if (!rst_n) begin
        act[g] = 1'b0;
      end else begin
        if (!rd_n[g] || !wr_n[g]) begin
          if (!act[g]) begin
            act[g] = 1'b1;
            cur[g].inst = g;
            cur[g].addr = addr[g];
            cur[g].ctl  = {~wr_n[g], data_oe[g], ~mreq_n[g], ~iorq_n[g], wrm_v[g]};
            cur[g].data = dout_v[g];
            cur[g].t2   = 1;
          end else begin
            cur[g].t2++;
          end
        end else if (act[g]) begin
          act[g] = 1'b0;
          if (beat_q.size() == 0) begin
            chk("unexpected_beat_inst", 32'(g), 32'hFFFF_FFFF);
          end else begin
            eb = beat_q.pop_front();
            chk("beat_inst", 32'(cur[g].inst), 32'(eb.inst));
            chk("beat_addr", cur[g].addr, eb.addr);
            chk("beat_ctl", 32'(cur[g].ctl), 32'(eb.ctl));
            if (eb.ctl[5]) chk("beat_wdata", 32'(cur[g].data), 32'(eb.data));
            chk("beat_t2_len", 32'(cur[g].t2), 32'(eb.t2));
          end
        end
        if (rsp_valid[g]) begin
          if (rsp_q.size() == 0) begin
            chk("unexpected_rsp_inst", 32'(g), 32'hFFFF_FFFF);
          end else begin
            er = rsp_q.pop_front();
            chk("rsp_inst", 32'(g), 32'(er.inst));
            chk("rsp_err", 32'(rsp_err[g]), 32'(er.err));
            if (er.chk_rd) chk("rsp_rdata", rsp_rdata[g], er.rdata);
            chk("rsp_latency", 32'(cyc - er.acc + 1), 32'(er.lat));
          end
        end
      end
    end
    if (stim_tmo != tmo_seen) begin
      chk("stim_wait_bound", 32'(stim_tmo), 32'(tmo_seen));
      tmo_seen = stim_tmo;
    end
    if (idle_req != idle_seen) begin
      idle_seen = idle_req;
      for (int g = 0; g < 3; g++) begin
        chk("idle_ready", 32'(req_ready[g]), 32'd1);
        chk("idle_strobes", 32'({rd_n[g], wr_n[g], mreq_n[g], iorq_n[g]}), 32'hF);
        chk("idle_oe", 32'(data_oe[g]), 32'd0);
        chk("idle_wrm", 32'(wrm_v[g]), 32'd3);
        chk("idle_addr", addr[g], 32'd0);
        chk("idle_dout", 32'(dout_v[g]), 32'd0);
        chk("idle_rsp", 32'({rsp_valid[g], rsp_err[g]}), 32'd0);
        chk("idle_rdata", rsp_rdata[g], 32'd0);
      end
    end
    if (done_req && !fin) begin
      chk("beats_left", 32'(beat_q.size()), 32'd0);
      chk("rsps_left", 32'(rsp_q.size()), 32'd0);
      fin = 1'b1;
    end
  end

  task automatic exp_beat(input int g, input logic [31:0] a, input logic wr,
                          input logic [15:0] d, input logic [1:0] wrm, input logic io,
                          input int t2);
    beat_t b;
    b.inst = g;
    b.addr = a;
    b.ctl  = {wr, wr, ~io, io, wrm};
    b.data = d;
    b.t2   = t2;
    beat_q.push_back(b);
  endtask

  // Called one step after a rising edge with the selected unit idle.
  task automatic issue(input int g, input logic [31:0] a, input logic [3:0] m,
                       input logic [31:0] d, input bit exp_rsp, input logic e_err,
                       input logic e_chk, input logic [31:0] e_rd, input int e_lat);
    rsp_t r;
    req_addr[g]  = a;
    req_wmask[g] = m;
    req_wdata[g] = d;
    req_valid[g] = 1'b1;
    @(posedge clk); #1;
    req_valid[g] = 1'b0;
    if (exp_rsp) begin
      r.inst = g; r.err = e_err; r.chk_rd = e_chk; r.rdata = e_rd;
      r.lat = e_lat; r.acc = cyc;
      rsp_q.push_back(r);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (beat_q.size() == 0 && rsp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) stim_tmo++;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic wait_low_rd(input int g);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!rd_n[g]) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) stim_tmo++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      req_valid[g] = 1'b0; req_addr[g] = '0; req_wmask[g] = '0; req_wdata[g] = '0;
      wait_n[g] = 1'b1; rdw[g] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    idle_req++;
    @(posedge clk); #1;

    // Two-beat memory read, unaligned address bits ignored.
    rdw[0] = 32'hDEAD_BEEF;
    exp_beat(0, 32'h0000_1000, 1'b0, 16'h0, 2'b11, 1'b0, 1);
    exp_beat(0, 32'h0000_1002, 1'b0, 16'h0, 2'b11, 1'b0, 1);
    issue(0, 32'h0000_1002, 4'b0000, 32'h0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 7);
    drain();

    // Write with low half masked off: only the upper beat runs.
    exp_beat(0, 32'h0000_2002, 1'b1, 16'h1234, 2'b00, 1'b0, 1);
    issue(0, 32'h0000_2000, 4'b1100, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'h0, 4);
    drain();

    // I/O read with MIN_WAIT=3.
    rdw[1] = 32'h0BAD_F00D;
    exp_beat(1, 32'hF000_0010, 1'b0, 16'h0, 2'b11, 1'b1, 3);
    exp_beat(1, 32'hF000_0012, 1'b0, 16'h0, 2'b11, 1'b1, 3);
    issue(1, 32'hF000_0010, 4'b0000, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0BAD_F00D, 11);
    drain();

    // wait_n low for 5 extra T2 cycles on beat 0.
    rdw[0] = 32'h55AA_1234;
    wait_n[0] = 1'b0;
    exp_beat(0, 32'h0000_3000, 1'b0, 16'h0, 2'b11, 1'b0, 6);
    exp_beat(0, 32'h0000_3002, 1'b0, 16'h0, 2'b11, 1'b0, 1);
    issue(0, 32'h0000_3000, 4'b0000, 32'h0, 1'b1, 1'b0, 1'b1, 32'h55AA_1234, 12);
    wait_low_rd(0);
    repeat (5) begin @(posedge clk); #1; end
    wait_n[0] = 1'b1;
    drain();

    // Timeout after 4 T2 cycles; beat 1 is never issued.
    wait_n[1] = 1'b0;
    exp_beat(1, 32'h0000_3000, 1'b0, 16'h0, 2'b11, 1'b0, 4);
    issue(1, 32'h0000_3000, 4'b0000, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 7);
    drain();
    wait_n[1] = 1'b1;

    // Byte bus write, lanes 0 and 2 only.
    exp_beat(2, 32'h0000_4000, 1'b1, 16'h00DD, 2'b10, 1'b0, 1);
    exp_beat(2, 32'h0000_4002, 1'b1, 16'h00BB, 2'b10, 1'b0, 1);
    issue(2, 32'h0000_4000, 4'b0101, 32'hAABB_CCDD, 1'b1, 1'b0, 1'b0, 32'h0, 7);
    drain();

    // Reset during T2 of beat 1: strobes drop, no response.
    rdw[0] = 32'h1111_2222;
    exp_beat(0, 32'h0000_5000, 1'b0, 16'h0, 2'b11, 1'b0, 1);
    issue(0, 32'h0000_5000, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (addr[0] == 32'h0000_5002) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) stim_tmo++;
    wait_n[0] = 1'b0;
    @(posedge clk); #1;
    wait_low_rd(0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    idle_req++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_n[0] = 1'b1;
    repeat (10) begin @(posedge clk); #1; end

    // New request accepted after reset release.
    exp_beat(0, 32'h0000_6000, 1'b1, 16'hF00D, 2'b00, 1'b0, 1);
    exp_beat(0, 32'h0000_6002, 1'b1, 16'hCAFE, 2'b00, 1'b0, 1);
    issue(0, 32'h0000_6000, 4'b1111, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 32'h0, 7);
    drain();

    done_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (fin) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) $display("FAIL final_checks: monitor did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
